// File: rtl/bsg_mux_segmented_buffered_pkg.sv
// Shared width helpers for the buffered segmented mux and its combinational core.
package bsg_mux_segmented_buffered_pkg;

   // Select field width; a 1-entry or 2-entry mux still needs one select bit.
   function automatic int sel_width_f(input int els);
      return (els <= 2) ? 1 : $clog2(els);
   endfunction

   function automatic int width_f(input int segments, input int segment_width);
      return segments * segment_width;
   endfunction

endpackage

// File: rtl/bsg_mux_segmented_n.sv
// Combinational els_p-way segmented mux; each segment picks its own source word.
// Segments with an out-of-range select read as zero and raise oor_o.
module bsg_mux_segmented_n
   import bsg_mux_segmented_buffered_pkg::*;
#(
   parameter int segments_p      = 64,
   parameter int segment_width_p = 1,
   parameter int els_p           = 2
) (
   input  logic [els_p*width_f(segments_p, segment_width_p)-1:0] data_i,
   input  logic [segments_p*sel_width_f(els_p)-1:0]              sel_i,
   output logic [width_f(segments_p, segment_width_p)-1:0]       data_o,
   output logic                                                  oor_o
);

   localparam int width_lp     = width_f(segments_p, segment_width_p);
   localparam int sel_width_lp = sel_width_f(els_p);

   logic [sel_width_lp-1:0] sel;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      data_o = '0;
      oor_o  = 1'b0;
      sel    = '0;
      for (int s = 0; s < segments_p; s++) begin
         sel = sel_i[s*sel_width_lp +: sel_width_lp];
         if (int'(sel) >= els_p) oor_o = 1'b1;
         for (int k = 0; k < els_p; k++) begin
            if (sel == sel_width_lp'(k))
               data_o[s*segment_width_p +: segment_width_p] =
                  data_i[k*width_lp + s*segment_width_p +: segment_width_p];
         end
      end
   end

endmodule

// File: rtl/bsg_mux_segmented_buffered.sv
// Segmented mux feeding a 2-entry elastic buffer (valid/ready in, valid/yumi out)
// with a sticky flag for accepted out-of-range selects.
module bsg_mux_segmented_buffered
   import bsg_mux_segmented_buffered_pkg::*;
#(
   parameter int segments_p      = 64,
   parameter int segment_width_p = 1,
   parameter int els_p           = 2
) (
   input  logic                                                  clk_i,
   input  logic                                                  reset_n_i,
   input  logic                                                  v_i,
   output logic                                                  ready_o,
   input  logic [els_p*width_f(segments_p, segment_width_p)-1:0] data_i,
   input  logic [segments_p*sel_width_f(els_p)-1:0]              sel_i,
   output logic                                                  v_o,
   output logic [width_f(segments_p, segment_width_p)-1:0]       data_o,
   input  logic                                                  yumi_i,
   output logic                                                  err_o
);

   localparam int width_lp = width_f(segments_p, segment_width_p);

   logic [width_lp-1:0] mux_data;
   logic                mux_oor;
   logic [width_lp-1:0] mem_r [2];
   logic                head_r, tail_r;
   logic [1:0]          count_r;
   logic                err_r;
   logic                enq, deq;

   bsg_mux_segmented_n #(
      .segments_p      (segments_p),
      .segment_width_p (segment_width_p),
      .els_p           (els_p)
   ) mux (
      .data_i (data_i),
      .sel_i  (sel_i),
      .data_o (mux_data),
      .oor_o  (mux_oor)
   );

   // Both handshakes are qualified by registered state, so outputs never see inputs combinationally.
   assign ready_o = (count_r != 2'd2);
   assign v_o     = (count_r != 2'd0);
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;
   assign data_o  = mem_r[head_r];
   assign err_o   = err_r;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         // NOTE: the two entries are reset so data_o reads zero straight out of reset.
         mem_r[0] <= '0;
         mem_r[1] <= '0;
         head_r   <= 1'b0;
         tail_r   <= 1'b0;
         count_r  <= 2'd0;
         err_r    <= 1'b0;
      end else begin
         if (enq) begin
            mem_r[tail_r] <= mux_data;
            tail_r        <= ~tail_r;
            if (mux_oor) err_r <= 1'b1;
         end
         if (deq) head_r <= ~head_r;
         case ({enq, deq})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o))
      else $error("yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_mux_segmented_buffered.sv
// Bench for two configurations: 64x1 bitwise 2-way, and 4x8 3-way with out-of-range selects.
module tb_bsg_mux_segmented_buffered;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Configuration A: 64 segments x 1 bit, 2 words.
   logic          a_v, a_ready, a_vo, a_yumi, a_err;
   logic [127:0]  a_data;
   logic [63:0]   a_sel, a_out;
   // Configuration B: 4 segments x 8 bits, 3 words.
   logic          b_v, b_ready, b_vo, b_yumi, b_err;
   logic [95:0]   b_data;
   logic [7:0]    b_sel;
   logic [31:0]   b_out;

   bsg_mux_segmented_buffered dut_a (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(a_v), .ready_o(a_ready), .data_i(a_data),
      .sel_i(a_sel), .v_o(a_vo), .data_o(a_out), .yumi_i(a_yumi), .err_o(a_err));

   bsg_mux_segmented_buffered #(.segments_p(4), .segment_width_p(8), .els_p(3)) dut_b (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(b_v), .ready_o(b_ready), .data_i(b_data),
      .sel_i(b_sel), .v_o(b_vo), .data_o(b_out), .yumi_i(b_yumi), .err_o(b_err));

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference mux: walk segments, decode each select as an integer, copy bits of the chosen word.
   function automatic logic [63:0] mux_model(input logic [255:0] data, input logic [127:0] sel,
                                             input int segs, input int sw, input int els,
                                             input int selw, output bit oor);
      logic [63:0] r = '0;
      oor = 0;
      for (int s = 0; s < segs; s++) begin
         int k = 0;
         for (int b = 0; b < selw; b++) if (sel[s*selw+b]) k += (1 << b);
         if (k >= els) oor = 1;
         else for (int b = 0; b < sw; b++) r[s*sw+b] = data[k*segs*sw + s*sw + b];
      end
      return r;
   endfunction

   // Behavioural buffer model: FIFO queues of at most two results plus sticky error flags.
   logic [63:0] qa[$], qb[$];
   bit          erra, errb, oor_a, oor_b;
   logic [63:0] ra, rb;
   int          enq_b_cnt = 0, deq_b_cnt = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         qa.delete(); qb.delete(); erra = 0; errb = 0;
      end else begin
         ra = mux_model({128'd0, a_data}, {64'd0, a_sel}, 64, 1, 2, 1, oor_a);
         rb = mux_model({160'd0, b_data}, {120'd0, b_sel}, 4, 8, 3, 2, oor_b);
         if (a_yumi && qa.size() > 0) void'(qa.pop_front());
         else if (a_v && qa.size() < 2) begin end
         if (a_v && (qa.size() < 2 || (a_yumi && qa.size() == 1))) begin end
         if (b_yumi && qb.size() > 0) begin void'(qb.pop_front()); deq_b_cnt++; end
      end
   end

   // Enqueue side evaluated against occupancy before this edge's dequeue.
   int occ_a_pre, occ_b_pre;
   always @(negedge clk) begin
      occ_a_pre = qa.size();
      occ_b_pre = qb.size();
   end

   always @(posedge clk) begin
      #0;
      if (rst_n) begin
         if (a_v && occ_a_pre < 2) begin qa.push_back(ra); if (oor_a) erra = 1; end
         if (b_v && occ_b_pre < 2) begin
            qb.push_back({32'd0, rb[31:0]}); enq_b_cnt++;
            if (oor_b) errb = 1;
         end
      end
   end

   // One compare process: every cycle, all outputs against the model (data only while valid).
   always @(negedge clk) begin
      #1;
      check("a_v_o", a_vo, qa.size() > 0);
      check("a_ready_o", a_ready, qa.size() < 2);
      check("a_err_o", a_err, erra);
      if (qa.size() > 0) check("a_data_o", a_out, qa[0]);
      check("b_v_o", b_vo, qb.size() > 0);
      check("b_ready_o", b_ready, qb.size() < 2);
      check("b_err_o", b_err, errb);
      if (qb.size() > 0) check("b_data_o", b_out, qb[0][31:0]);
   end

   task automatic set_rand(input bit va, input bit ya, input bit vb, input bit yb);
      a_v    = va;
      a_yumi = ya && (qa.size() > 0);
      a_data = {$urandom, $urandom, $urandom, $urandom};
      a_sel  = {$urandom, $urandom};
      b_v    = vb;
      b_yumi = yb && (qb.size() > 0);
      b_data = {$urandom, $urandom, $urandom};
      b_sel  = 8'($urandom_range(0, 255));
   endtask

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic drain();
      repeat (3) begin set_rand(0, 1, 0, 1); tick(); end
   endtask

   logic [63:0] x1, x2;
   bit          dummy_oor;
   int          enq0, deq0;

   initial begin
      // Pin the model itself with hand-computed results.
      check("model_bitwise", mux_model({128'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
            {64'd0, 64'hA5A5_0F0F_0000_FFFF}, 64, 1, 2, 1, dummy_oor), 64'hA5A5_0F0F_0000_FFFF);
      check("model_3way", mux_model({160'd0, 32'h33333333, 32'h22222222, 32'h11111111},
            {120'd0, 8'hE4}, 4, 8, 3, 2, dummy_oor), 64'h0000_0000_0033_2211);
      check("model_3way_oor", 64'(dummy_oor), 64'd1);

      // Reset held three cycles with v_i high.
      rst_n = 1'b0;
      repeat (3) begin
         set_rand(1, 0, 1, 0);
         tick();
         check("reset_a_data_zero", a_out, 64'd0);
         check("reset_b_data_zero", {32'd0, b_out}, 64'd0);
      end
      rst_n = 1'b1;
      set_rand(0, 0, 0, 0);
      tick();
      check("post_reset_a_v", a_vo, 0);
      check("post_reset_b_v", b_vo, 0);

      // Directed bitwise and 3-way merges.
      set_rand(0, 0, 0, 0);
      a_v = 1; a_data = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}; a_sel = 64'hA5A5_0F0F_0000_FFFF;
      b_v = 1; b_data = {32'h33333333, 32'h22222222, 32'h11111111}; b_sel = 8'hE4;
      tick();
      check("bitwise_v", a_vo, 1);
      check("bitwise_data", a_out, 64'hA5A5_0F0F_0000_FFFF);
      check("seg3_data", {32'd0, b_out}, 64'h0000_0000_0033_2211);
      check("seg3_err", b_err, 1);
      drain();
      check("seg3_err_sticky", b_err, 1);

      // Backpressure on B: two enqueues fill it, a third offer is refused.
      set_rand(0, 0, 1, 0); x1 = mux_model({160'd0, b_data}, {120'd0, b_sel}, 4, 8, 3, 2, dummy_oor); tick();
      set_rand(0, 0, 1, 0); x2 = mux_model({160'd0, b_data}, {120'd0, b_sel}, 4, 8, 3, 2, dummy_oor); tick();
      check("bp_full_ready", b_ready, 0);
      check("bp_head_first", {32'd0, b_out}, x1);
      set_rand(0, 0, 1, 0); tick();
      check("bp_third_refused", b_ready, 0);
      check("bp_head_still_first", {32'd0, b_out}, x1);
      set_rand(0, 0, 0, 1); tick();
      check("bp_ready_back", b_ready, 1);
      check("bp_head_second", {32'd0, b_out}, x2);
      set_rand(0, 0, 0, 1); tick();
      check("bp_empty", b_vo, 0);

      // Full-throughput streaming.
      drain();
      enq0 = enq_b_cnt; deq0 = deq_b_cnt;
      repeat (100) begin set_rand(1, 1, 1, 1); tick(); end
      set_rand(0, 1, 0, 1); tick();
      check("stream_enq_count", 64'(enq_b_cnt - enq0), 64'd100);
      check("stream_deq_count", 64'(deq_b_cnt - deq0), 64'd100);

      // Random mixed traffic.
      repeat (300) begin
         set_rand($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         tick();
      end

      // Reset mid-stream at occupancy 2, with same-cycle v_i/yumi_i offered.
      drain();
      repeat (2) begin set_rand(1, 0, 1, 0); tick(); end
      check("pre_reset_full", b_ready, 0);
      rst_n = 1'b0;
      set_rand(1, 1, 1, 1);
      tick();
      rst_n = 1'b1;
      set_rand(0, 0, 0, 0);
      tick();
      check("midreset_a_v", a_vo, 0);
      check("midreset_b_v", b_vo, 0);
      check("midreset_b_err", b_err, 0);
      repeat (50) begin
         set_rand($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         tick();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bsg_mux_segmented_buffered.md
Name: bsg_mux_segmented_buffered

Overview:
- Registered, flow-controlled, N-way segmented mux; the parametrised successor of the 2-way bitwise mux.
- Each output segment independently selects one of els_p input words using its own select field.
- The result is enqueued into a 2-entry elastic buffer with valid/ready input and valid/yumi output.
- Sits between datapath stages needing per-lane merge (byte-enable merge, lane steering) with backpressure.

Parameters:
- segments_p, 64, number of independently selected segments.
- segment_width_p, 1, bits per segment; width = segments_p*segment_width_p.
- els_p, 2, number of input words (>=2).
- sel_width (localparam), ceil(log2(els_p)), select bits per segment.

Ports:
- clk_i  input  1  clock.
- reset_n_i  input  1  synchronous, active-low reset.
- v_i  input  1  input word set valid.
- ready_o  output  1  block can accept this cycle.
- data_i  input  els_p*width  input words; word k at [k*width +: width].
- sel_i  input  segments_p*sel_width  select for segment s at [s*sel_width +: sel_width].
- v_o  output  1  data_o valid.
- data_o  output  width  head-of-buffer muxed result.
- yumi_i  input  1  consumer takes data_o this cycle; legal only when v_o=1.
- err_o  output  1  sticky: an out-of-range select was accepted.

Behaviour:
- Reset is sampled on the clk_i edge while reset_n_i=0. During reset and in the first cycle after: v_o=0, ready_o=1, data_o=0, err_o=0, buffer empty.
- Mux function: segment s of the result = segment s of word sel_s when sel_s < els_p. When sel_s >= els_p (only possible for non-power-of-2 els_p), the segment is all zeros.
- Enqueue: occurs when v_i & ready_o. The mux is evaluated on that cycle's data_i/sel_i. data_i/sel_i are ignored when no enqueue occurs.
- Latency: enqueue at edge t makes the result visible on data_o with v_o=1 from cycle t+1, provided the buffer was empty. No combinational path from any input to v_o, data_o or err_o.
- Dequeue: occurs when yumi_i=1. The head entry is removed at the edge, and the next entry, if any, appears the following cycle.
- Occupancy: 0, 1 or 2 entries.
  - ready_o = (occupancy < 2), registered.
  - v_o = (occupancy > 0).
- Simultaneous events:
  - Enqueue and dequeue at occupancy 1: occupancy stays 1 and the new result becomes head.
  - At occupancy 2: ready_o=0, so only a dequeue can occur; occupancy goes to 1.
  - At occupancy 0: yumi_i must be 0.
- Full-throughput: with yumi_i held high and v_i held high, one result per cycle, ready_o never drops.
- Order: strictly FIFO. No entry is duplicated or dropped.
- data_o when v_o=0: holds the last dequeued value (not required to be zero after first use). Verification must not check it.
- err_o: set on the edge of any enqueue containing an out-of-range select; cleared only by reset. Always 0 when els_p is a power of 2.
- Reset mid-operation: all buffered entries are discarded, err_o clears, and same-cycle v_i/yumi_i are ignored.
- Protocol violation (yumi_i & ~v_o): simulation assertion fires. The buffer state is unchanged by it.

Decomposition:
- Shared package: sel-width function (safe ceil-log2, min 1) and the width computation. No typedefs needed.
- Sub-module bsg_mux_segmented_n: purely combinational els_p-way segmented mux with out-of-range detection output.
- Top: the 2-entry buffer (two data registers, head pointer, tail pointer, occupancy counter) plus the err_o flag.

Test Plan:
- Reset/idle: hold reset_n_i=0 three cycles with v_i=1 -> v_o=0, ready_o=1, err_o=0 throughout and one cycle after release.
- Bitwise mode (64x1, els_p=2): data0=64'h0, data1=64'hFFFF_FFFF_FFFF_FFFF, sel=64'hA5A5_0F0F_0000_FFFF -> next cycle v_o=1, data_o=64'hA5A5_0F0F_0000_FFFF.
- Segmented 3-way (segments_p=4, segment_width_p=8, els_p=3):
  - words 32'h11111111, 32'h22222222, 32'h33333333 with sels {3,2,1,0} (seg3..seg0) -> data_o=32'h00332211, err_o=1 next cycle and stays 1 until reset.
- Backpressure: yumi_i=0, enqueue results A,B on consecutive cycles -> ready_o=0 after second. A third v_i is not accepted. Assert yumi_i twice -> A then B. ready_o returns to 1 after first yumi.
- Streaming: v_i=1, yumi_i=1 for 100 cycles with random data/sel -> 100 outputs matching the reference model in order, ready_o constant 1.
- Reset mid-stream: occupancy 2, pulse reset_n_i low one cycle -> v_o=0 next cycle, stale entries never appear, and subsequent traffic is correct.
